// File: rtl/rst_sequencer_pkg.sv
// Shared constants for the reset sequencer: bus geometry, register map, cause bits.
package rst_sequencer_pkg;

    localparam int unsigned RST_VA_WIDTH  = 8;
    localparam int unsigned BUS_WIDTH     = 8;
    localparam int unsigned BUS_ACC_WIDTH = 2;

    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

    localparam logic [RST_VA_WIDTH-1:0] RST_REG_CTRL  = 8'd0;
    localparam logic [RST_VA_WIDTH-1:0] RST_REG_HOLD  = 8'd1;
    localparam logic [RST_VA_WIDTH-1:0] RST_REG_STAT  = 8'd2;
    localparam logic [RST_VA_WIDTH-1:0] RST_REG_CAUSE = 8'd3;

    localparam int unsigned RST_CAUSE_EXT   = 0;
    localparam int unsigned RST_CAUSE_SWALL = 1;
    localparam int unsigned RST_CAUSE_SWONE = 2;
    localparam int unsigned RST_CAUSE_W     = 3;

    localparam int unsigned RST_CH_MAX = 8;

    typedef logic [BUS_WIDTH-1:0] bus_data_t;

    // CTRL value 0 targets every channel; value n targets channel n-1.
    function automatic logic ctrl_selects(bus_data_t wd, int unsigned idx);
        return (wd == '0) || (wd == bus_data_t'(idx + 1));
    endfunction

endpackage

// File: rtl/rst_chan_cnt.sv
// One reset channel: pulse down-counter plus the flop that drives its active-low reset.
module rst_chan_cnt #(
    parameter int unsigned CW         = 5,
    parameter int unsigned RESET_VAL  = 16,
    parameter int unsigned RELOAD_VAL = 16
) (
    input  logic clk,
    input  logic rst_ib,
    input  logic run,      // synchronised external reset has been released
    input  logic reload,   // software pulse request for this channel
    input  logic hold,     // next-state software hold for this channel
    output logic rst_o
);

    localparam logic [CW-1:0] CNT_RESET  = CW'(RESET_VAL);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(RELOAD_VAL);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload restarts a pulse even mid-count; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = CNT_RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter and output flop frozen until the synchroniser releases them.
    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            cnt_q <= CNT_RESET;
            rst_o <= 1'b0;
        end else if (run) begin
            cnt_q <= cnt_d;
            rst_o <= (cnt_d == '0) & ~hold;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: bus-programmable, per-channel stretched and staggered module resets.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int unsigned CH           = 4,
    parameter int unsigned PULSE_CYCLES = 16,
    parameter int unsigned STAGGER      = 4
) (
    input  logic                     clk,
    input  logic                     rst_ib,
    output logic [CH-1:0]            rst_ob,
    input  logic [RST_VA_WIDTH-1:0]  addr,
    input  logic                     w_rb,
    input  logic [BUS_ACC_WIDTH-1:0] acc,
    output logic [BUS_WIDTH-1:0]     rdata,
    input  logic [BUS_WIDTH-1:0]     wdata,
    input  logic                     req,
    output logic                     resp,
    output logic                     fault
);

    localparam int unsigned CW = $clog2(PULSE_CYCLES + (CH - 1) * STAGGER + 1);

    logic [1:0]             sync_q;
    logic                   rst_sync;
    logic                   invld;
    logic                   legal;
    logic                   ctrl_wr;
    logic                   hold_wr;
    logic                   cause_wr;
    logic [CH-1:0]          hold_q;
    logic [CH-1:0]          hold_d;
    logic [RST_CAUSE_W-1:0] cause_q;
    logic [RST_CAUSE_W-1:0] cause_d;
    logic [BUS_WIDTH-1:0]   rd_mux;

    assign rst_sync = sync_q[1];

    // Release of rst_ib is synchronised; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Illegal-access decode; a faulting request has no side effects at all.
    always_comb begin
        invld = req & ((addr > RST_REG_CAUSE)
                     | (acc != BUS_ACC_1B)
                     | (w_rb & (addr == RST_REG_STAT))
                     | (~w_rb & (addr == RST_REG_CTRL))
                     | (w_rb & (addr == RST_REG_CTRL) & (wdata > bus_data_t'(CH))));
    end

    assign fault    = invld;
    assign legal    = req & ~invld;
    assign ctrl_wr  = legal & w_rb & (addr == RST_REG_CTRL);
    assign hold_wr  = legal & w_rb & (addr == RST_REG_HOLD);
    assign cause_wr = legal & w_rb & (addr == RST_REG_CAUSE);

    // Next-state for HOLD and CAUSE (CAUSE is write-one-to-clear, set by CTRL writes).
    always_comb begin
        hold_d  = hold_q;
        cause_d = cause_q;
        if (hold_wr) begin
            hold_d = wdata[CH-1:0];
        end
        if (cause_wr) begin
            cause_d = cause_q & ~wdata[RST_CAUSE_W-1:0];
        end
        if (ctrl_wr) begin
            if (wdata == '0) begin
                cause_d[RST_CAUSE_SWALL] = 1'b1;
            end else begin
                cause_d[RST_CAUSE_SWONE] = 1'b1;
            end
        end
    end

    // Read mux; unused upper bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (addr)
            RST_REG_HOLD:  rd_mux[CH-1:0] = hold_q;
            RST_REG_STAT:  rd_mux[CH-1:0] = ~rst_ob;
            RST_REG_CAUSE: rd_mux[RST_CAUSE_W-1:0] = cause_q;
            default:       rd_mux = '0;
        endcase
    end

    // Bus-visible registers and the response path.
    always_ff @(posedge clk or negedge rst_ib) begin
        if (!rst_ib) begin
            hold_q  <= '0;
            cause_q <= RST_CAUSE_W'(1) << RST_CAUSE_EXT;
            resp    <= 1'b0;
            rdata   <= '0;
        end else begin
            hold_q  <= hold_d;
            cause_q <= cause_d;
            resp    <= legal;
            rdata   <= (legal & ~w_rb) ? rd_mux : '0;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : gen_chan
        rst_chan_cnt #(
            .CW         (CW),
            .RESET_VAL  (PULSE_CYCLES + g * STAGGER),
            .RELOAD_VAL (PULSE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst_ib (rst_ib),
            .run    (rst_sync),
            .reload (ctrl_wr & ctrl_selects(wdata, g)),
            .hold   (hold_d[g]),
            .rst_o  (rst_ob[g])
        );
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with a read-data scoreboard.
module tb_rst_sequencer;

    localparam int unsigned CH    = 4;
    localparam int unsigned PULSE = 16;
    localparam int unsigned STAG  = 4;

    logic       clk;
    logic       rst_ib;
    logic [3:0] rst_ob;
    logic [7:0] addr;
    logic       w_rb;
    logic [1:0] acc;
    logic [7:0] rdata;
    logic [7:0] wdata;
    logic       req;
    logic       resp;
    logic       fault;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    rst_sequencer #(
        .CH           (CH),
        .PULSE_CYCLES (PULSE),
        .STAGGER      (STAG)
    ) dut (
        .clk    (clk),
        .rst_ib (rst_ib),
        .rst_ob (rst_ob),
        .addr   (addr),
        .w_rb   (w_rb),
        .acc    (acc),
        .rdata  (rdata),
        .wdata  (wdata),
        .req    (req),
        .resp   (resp),
        .fault  (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus request; reads push their expected data, popped when resp appears.
    task automatic bus(input string tag, input logic w, input logic [7:0] a,
                       input logic [1:0] ac, input logic [7:0] wd,
                       input logic fexp, input logic [7:0] rexp);
        req = 1'b1; w_rb = w; addr = a; acc = ac; wdata = wd;
        if (!fexp && !w) exp_q.push_back(rexp);
        #1;
        chk({tag, ".fault"}, 32'(fault), 32'(fexp));
        @(posedge clk);
        #1;
        req = 1'b0; w_rb = 1'b0; addr = '0; acc = '0; wdata = '0;
        chk({tag, ".resp"}, 32'(resp), 32'(!fexp));
        if (resp && !w) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'(1), 32'(0));
            end else begin
                chk({tag, ".rdata"}, 32'(rdata), 32'(exp_q.pop_front()));
            end
        end else begin
            chk({tag, ".rdata0"}, 32'(rdata), 32'(0));
        end
    endtask

    // Release rst_ib and check the staggered release edge by edge.
    task automatic release_check(input string tag);
        logic [3:0] e;
        rst_ib = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step(1);
            for (int i = 0; i < 4; i++) e[i] = (k >= 2 + PULSE + i * STAG);
            chk($sformatf("%s.rel%0d", tag, k), 32'(rst_ob), 32'(e));
        end
    endtask

    initial begin
        req = 0; w_rb = 0; addr = 0; acc = 0; wdata = 0;
        rst_ib = 1'b1;

        // 1 POR
        #2 rst_ib = 1'b0;
        #1 chk("por.async", 32'(rst_ob), 32'h0);
        step(5);
        chk("por.held", 32'(rst_ob), 32'h0);
        release_check("por");
        bus("por.cause", 0, 8'd3, 2'd0, 8'h00, 0, 8'h01);

        // 2 single pulse on channel 1, then CAUSE W1C
        bus("t2.ctrl", 1, 8'd0, 2'd0, 8'h02, 0, 8'h00);
        chk("t2.low_first", 32'(rst_ob), 32'hd);
        step(15);
        chk("t2.low_last", 32'(rst_ob), 32'hd);
        step(1);
        chk("t2.high", 32'(rst_ob), 32'hf);
        bus("t2.cause", 0, 8'd3, 2'd0, 8'h00, 0, 8'h05);
        bus("t2.w1c", 1, 8'd3, 2'd0, 8'h07, 0, 8'h00);
        bus("t2.cause_clr", 0, 8'd3, 2'd0, 8'h00, 0, 8'h00);

        // 3 re-trigger mid-pulse on channel 0
        bus("t3.ctrl_a", 1, 8'd0, 2'd0, 8'h01, 0, 8'h00);
        step(9);
        chk("t3.mid", 32'(rst_ob), 32'he);
        bus("t3.ctrl_b", 1, 8'd0, 2'd0, 8'h01, 0, 8'h00);
        chk("t3.t11", 32'(rst_ob), 32'he);
        step(15);
        chk("t3.t26", 32'(rst_ob), 32'he);
        step(1);
        chk("t3.t27", 32'(rst_ob), 32'hf);

        // 3b pulse all, no stagger; partial and empty W1C
        bus("t3b.ctrl", 1, 8'd0, 2'd0, 8'h00, 0, 8'h00);
        chk("t3b.low_first", 32'(rst_ob), 32'h0);
        step(15);
        chk("t3b.low_last", 32'(rst_ob), 32'h0);
        step(1);
        chk("t3b.high", 32'(rst_ob), 32'hf);
        bus("t3b.cause", 0, 8'd3, 2'd0, 8'h00, 0, 8'h06);
        bus("t3b.w1c_b1", 1, 8'd3, 2'd0, 8'h02, 0, 8'h00);
        bus("t3b.w1c_none", 1, 8'd3, 2'd0, 8'h00, 0, 8'h00);
        bus("t3b.cause2", 0, 8'd3, 2'd0, 8'h00, 0, 8'h04);

        // 4 HOLD
        bus("t4.hold", 1, 8'd1, 2'd0, 8'h05, 0, 8'h00);
        chk("t4.ob", 32'(rst_ob), 32'ha);
        bus("t4.stat", 0, 8'd2, 2'd0, 8'h00, 0, 8'h05);
        bus("t4.hold_rd", 0, 8'd1, 2'd0, 8'h00, 0, 8'h05);
        bus("t4.clear", 1, 8'd1, 2'd0, 8'h00, 0, 8'h00);
        chk("t4.released", 32'(rst_ob), 32'hf);
        bus("t4.hold_upper", 1, 8'd1, 2'd0, 8'hf0, 0, 8'h00);
        bus("t4.hold_upper_rd", 0, 8'd1, 2'd0, 8'h00, 0, 8'h00);

        // 5 faults: no resp, no state change
        bus("t5.ctrl5", 1, 8'd0, 2'd0, 8'h05, 1, 8'h00);
        bus("t5.acc2b", 1, 8'd1, 2'd1, 8'h0f, 1, 8'h00);
        bus("t5.addr4", 0, 8'd4, 2'd0, 8'h00, 1, 8'h00);
        bus("t5.wstat", 1, 8'd2, 2'd0, 8'h0f, 1, 8'h00);
        bus("t5.rctrl", 0, 8'd0, 2'd0, 8'h00, 1, 8'h00);
        bus("t5.cause4b", 1, 8'd3, 2'd2, 8'hff, 1, 8'h00);
        chk("t5.ob", 32'(rst_ob), 32'hf);
        step(20);
        chk("t5.ob_late", 32'(rst_ob), 32'hf);
        bus("t5.hold_rd", 0, 8'd1, 2'd0, 8'h00, 0, 8'h00);
        bus("t5.cause_rd", 0, 8'd3, 2'd0, 8'h00, 0, 8'h04);

        // 6 external reset in the middle of a single-channel pulse
        bus("t6.hold", 1, 8'd1, 2'd0, 8'h02, 0, 8'h00);
        bus("t6.ctrl", 1, 8'd0, 2'd0, 8'h04, 0, 8'h00);
        chk("t6.pulse", 32'(rst_ob), 32'h5);
        step(4);
        rst_ib = 1'b0;
        #1 chk("t6.async", 32'(rst_ob), 32'h0);
        step(3);
        chk("t6.held", 32'(rst_ob), 32'h0);
        release_check("t6");
        bus("t6.hold_rd", 0, 8'd1, 2'd0, 8'h00, 0, 8'h00);
        bus("t6.cause_rd", 0, 8'd3, 2'd0, 8'h00, 0, 8'h01);

        chk("sb.drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
